// File: rtl/corefifo_wr_ptr_ctrl_pkg.sv
// Shared definitions for the async FIFO pointer controllers: default
// geometry, gray/binary conversion helpers and the full-compare helper.
// Helpers work on a 32-bit word; callers zero-extend their pointers and
// cast the result back to pointer width.
package corefifo_wr_ptr_ctrl_pkg;

   localparam int CFIFO_ADDRWIDTH = 3;
   localparam int PTRW            = CFIFO_ADDRWIDTH + 1;
   localparam int CFIFO_MAXW      = 32;

   typedef logic [CFIFO_MAXW-1:0] cfifo_word_t;

   // Binary to reflected gray code.
   function automatic cfifo_word_t bin2gray(input cfifo_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   function automatic cfifo_word_t gray2bin(input cfifo_word_t gray);
      cfifo_word_t bin;
      bin = '0;
      for (int i = 0; i < CFIFO_MAXW; i++) begin
         bin[i] = ^(gray >> i);
      end
      return bin;
   endfunction

   // Full when the write gray pointer equals the read gray pointer with its
   // two MSBs inverted (one lap ahead, same address).
   function automatic logic ptr_full_match(input cfifo_word_t wr_gray,
                                           input cfifo_word_t rd_gray,
                                           input int          ptrw);
      cfifo_word_t flip;
      flip = 32'd3 << (ptrw - 2);
      return (wr_gray == (rd_gray ^ flip));
   endfunction

endpackage

// File: rtl/corefifo_gray2bin.sv
// Purely combinational gray-to-binary converter, shared by the write- and
// read-side pointer controllers.
module corefifo_gray2bin
   import corefifo_wr_ptr_ctrl_pkg::*;
#(
   parameter int WIDTH = PTRW
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   logic [WIDTH-1:0] bin_s;

   // Prefix XOR from the MSB down; no feedback on bin_s itself.
   always_comb begin
      bin_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin_s[i] = ^(gray >> i);
      end
   end

   assign bin = bin_s;

endmodule

// File: rtl/corefifo_wr_ptr_ctrl.sv
// Write-domain pointer and flag controller of the async FIFO. Holds the
// binary/gray write pointers, drives the memory write port and derives
// full, almost-full, fill level and overflow from the synchronized read
// pointer. All flags are registered; rd_ptr_gray_sync reaches outputs only
// through registers.
module corefifo_wr_ptr_ctrl
   import corefifo_wr_ptr_ctrl_pkg::*;
#(
   parameter int ADDRWIDTH    = CFIFO_ADDRWIDTH,
   parameter int AFULL_THRESH = 6
) (
   input  logic                 clk,
   input  logic                 arstn,
   input  logic                 srstn,
   input  logic                 we,
   input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
   output logic [ADDRWIDTH:0]   wr_ptr_gray,
   output logic [ADDRWIDTH-1:0] waddr,
   output logic                 wen_mem,
   output logic                 full,
   output logic                 afull,
   output logic [ADDRWIDTH:0]   wrcnt,
   output logic                 overflow
);

   localparam int                WPTRW          = ADDRWIDTH + 1;
   localparam logic [WPTRW-1:0]  AFULL_THRESH_W = WPTRW'(AFULL_THRESH);

   logic [WPTRW-1:0] wr_ptr_bin_r;
   logic [WPTRW-1:0] wr_ptr_gray_r;
   logic             full_r;
   logic             afull_r;
   logic [WPTRW-1:0] wrcnt_r;
   logic             overflow_r;

   logic             accept_s;
   logic [WPTRW-1:0] wr_ptr_bin_nxt_s;
   logic [WPTRW-1:0] wr_ptr_gray_nxt_s;
   logic [WPTRW-1:0] rd_bin_s;
   logic [WPTRW-1:0] fill_nxt_s;
   logic             full_nxt_s;
   logic             afull_nxt_s;
   logic             overflow_nxt_s;

   corefifo_gray2bin #(
      .WIDTH (WPTRW)
   ) u_rd_gray2bin (
      .gray (rd_ptr_gray_sync),
      .bin  (rd_bin_s)
   );

   // Next-state pointers and flags; a read-pointer advance and a write in
   // the same cycle are both folded into the fill computation.
   always_comb begin
      accept_s          = we & ~full_r;
      wr_ptr_bin_nxt_s  = wr_ptr_bin_r + {{ADDRWIDTH{1'b0}}, accept_s};
      wr_ptr_gray_nxt_s = WPTRW'(bin2gray(cfifo_word_t'(wr_ptr_bin_nxt_s)));
      fill_nxt_s        = wr_ptr_bin_nxt_s - rd_bin_s;
      full_nxt_s        = ptr_full_match(cfifo_word_t'(wr_ptr_gray_nxt_s),
                                         cfifo_word_t'(rd_ptr_gray_sync),
                                         WPTRW);
      afull_nxt_s       = (fill_nxt_s >= AFULL_THRESH_W);
      overflow_nxt_s    = we & full_r;
   end

   // Pointer and flag registers with async and sync clear.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr_bin_r  <= '0;
         wr_ptr_gray_r <= '0;
         full_r        <= 1'b0;
         afull_r       <= 1'b0;
         wrcnt_r       <= '0;
         overflow_r    <= 1'b0;
      end else if (!srstn) begin
         wr_ptr_bin_r  <= '0;
         wr_ptr_gray_r <= '0;
         full_r        <= 1'b0;
         afull_r       <= 1'b0;
         wrcnt_r       <= '0;
         overflow_r    <= 1'b0;
      end else begin
         wr_ptr_bin_r  <= wr_ptr_bin_nxt_s;
         wr_ptr_gray_r <= wr_ptr_gray_nxt_s;
         full_r        <= full_nxt_s;
         afull_r       <= afull_nxt_s;
         wrcnt_r       <= fill_nxt_s;
         overflow_r    <= overflow_nxt_s;
      end
   end

   assign wr_ptr_gray = wr_ptr_gray_r;
   assign waddr       = wr_ptr_bin_r[ADDRWIDTH-1:0];
   assign wen_mem     = accept_s;
   assign full        = full_r;
   assign afull       = afull_r;
   assign wrcnt       = wrcnt_r;
   assign overflow    = overflow_r;

endmodule
